// File: rtl/nibble_serializer_pkg.sv
// Package for the nibble serializer: FSM state type, per-bit cell select
// type and the down-counter width helper.
package nibble_serializer_pkg;

`include "nibble_serializer_defs.vh"

    typedef enum logic {
        ST_IDLE  = `ST_IDLE,
        ST_SHIFT = `ST_SHIFT
    } state_t;

    // Per-cell operation for the shift register slices.
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'd0,
        SEL_LOAD  = 2'd1,
        SEL_SHIFT = 2'd2
    } cell_sel_t;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/nibble_serializer_defs.vh
// Shared state encodings for the nibble serializer FSM.
`ifndef NIBBLE_SERIALIZER_DEFS_VH
`define NIBBLE_SERIALIZER_DEFS_VH

`define ST_IDLE  1'b0
`define ST_SHIFT 1'b1

`endif

// File: rtl/nibble_serializer_shift_cell.sv
// shift_cell: one bit slice of the serializer's shift register.
// Ports:
//   clock     falling-edge clock
//   rst_n     asynchronous active-low reset, clears the bit
//   sel       load / shift / hold select
//   load_bit  parallel input bit, taken on SEL_LOAD
//   shift_bit neighbouring bit, taken on SEL_SHIFT
//   q         stored bit
module shift_cell
    import nibble_serializer_pkg::*;
(
    input  logic      clock,
    input  logic      rst_n,
    input  cell_sel_t sel,
    input  logic      load_bit,
    input  logic      shift_bit,
    output logic      q
);

    always_ff @(negedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            case (sel)
                SEL_LOAD:  q <= load_bit;
                SEL_SHIFT: q <= shift_bit;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/nibble_serializer.sv
// nibble_serializer: parallel-in, serial-out shifter with a ready/load
// handshake. A WIDTH-bit word is accepted on a falling edge where load and
// ready are both high, then sent one bit per cycle on sout with bit_valid
// high for exactly WIDTH cycles, followed by a one-cycle done pulse.
// Ports:
//   clock      single clock, all state changes on the falling edge
//   rst_n      asynchronous active-low reset, discards any partial frame
//   in         parallel word, sampled only on an accepting edge
//   load       request to transmit in
//   ready      a word can be accepted on the next falling edge
//   sout       registered serial data
//   bit_valid  sout carries a payload bit
//   busy       frame in progress
//   done       one-cycle pulse after the last bit of a frame
module nibble_serializer
    import nibble_serializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    output logic             ready,
    output logic             sout,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             sout_reg, sout_next;
    logic             bit_valid_reg, bit_valid_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    cell_sel_t        cell_sel;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_in;
    logic             first_bit;
    logic             next_bit;
    logic             accept;

    // The register rotates so every stored bit feeds a neighbour; the bit
    // wrapping around is never sent because cnt ends the frame first.
    // shreg keeps the whole word as loaded; sout already holds the head bit,
    // so the next bit to send sits one position behind the head.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            if (MSB_FIRST != 0) begin : g_left
                assign shift_in[gi] = shreg[(gi + WIDTH - 1) % WIDTH];
            end else begin : g_right
                assign shift_in[gi] = shreg[(gi + 1) % WIDTH];
            end

            shift_cell u_cell (
                .clock     (clock),
                .rst_n     (rst_n),
                .sel       (cell_sel),
                .load_bit  (in[gi]),
                .shift_bit (shift_in[gi]),
                .q         (shreg[gi])
            );
        end
    endgenerate

    assign first_bit = (MSB_FIRST != 0) ? in[WIDTH-1]    : in[0];
    assign next_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-2] : shreg[1];

    // Ready also in the last-bit cycle, which allows back-to-back frames.
    assign ready  = (state_reg == ST_IDLE) ||
                    ((state_reg == ST_SHIFT) && (cnt_reg == CNT_W'(1)));
    assign accept = load && ready;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        sout_next      = sout_reg;
        bit_valid_next = bit_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
        cell_sel       = SEL_HOLD;

        if (accept) begin
            // Accepting out of the last-bit cycle still ends the old frame.
            done_next      = (state_reg == ST_SHIFT);
            state_next     = ST_SHIFT;
            cnt_next       = CNT_W'(WIDTH);
            sout_next      = first_bit;
            bit_valid_next = 1'b1;
            busy_next      = 1'b1;
            cell_sel       = SEL_LOAD;
        end else if (state_reg == ST_SHIFT) begin
            if (cnt_reg > CNT_W'(1)) begin
                cnt_next  = cnt_reg - CNT_W'(1);
                sout_next = next_bit;
                cell_sel  = SEL_SHIFT;
            end else begin
                done_next      = 1'b1;
                state_next     = ST_IDLE;
                cnt_next       = '0;
                sout_next      = 1'b0;
                bit_valid_next = 1'b0;
                busy_next      = 1'b0;
            end
        end
    end

    always_ff @(negedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            sout_reg      <= 1'b0;
            bit_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            sout_reg      <= sout_next;
            bit_valid_reg <= bit_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    assign sout      = sout_reg;
    assign bit_valid = bit_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_nibble_serializer.sv
// Bench for nibble_serializer: an MSB-first and an LSB-first instance share
// the same stimulus. A frame-level model (current word + bits remaining)
// predicts every output each cycle; directed scenarios pin the model with
// literal bit sequences and pulse counts, then random traffic with
// occasional asynchronous resets follows.
module tb_nibble_serializer;

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       load  = 1'b0;
    logic [3:0] din   = 4'h0;

    logic ready_m, sout_m, bv_m, busy_m, done_m;
    logic ready_l, sout_l, bv_l, busy_l, done_l;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(1)) u_msb (
        .clock(clock), .rst_n(rst_n), .in(din), .load(load),
        .ready(ready_m), .sout(sout_m), .bit_valid(bv_m), .busy(busy_m), .done(done_m)
    );

    nibble_serializer #(.WIDTH(4), .MSB_FIRST(0)) u_lsb (
        .clock(clock), .rst_n(rst_n), .in(din), .load(load),
        .ready(ready_l), .sout(sout_l), .bit_valid(bv_l), .busy(busy_l), .done(done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // left = payload bits still to appear on sout, including the current one.
    logic [3:0] word_e = 4'h0;
    int         left_e = 0;
    logic       done_e = 1'b0;

    always @(negedge clock or negedge rst_n) begin
        if (!rst_n) begin
            left_e <= 0;
            done_e <= 1'b0;
        end else begin
            done_e <= (left_e == 1);
            if (load && left_e <= 1) begin
                word_e <= din;
                left_e <= 4;
            end else if (left_e > 0) begin
                left_e <= left_e - 1;
            end
        end
    end

    // ---------------- per-cycle compare + window log ----------------
    bit log_m[$];
    bit log_l[$];
    int done_cnt  = 0;
    int busy_fall = 0;
    int nz_cnt    = 0;
    int rdy_low   = 0;
    logic prev_busy = 1'b0;

    always @(posedge clock) begin
        logic act_e;
        act_e = (left_e > 0);
        check("ready_msb", ready_m, left_e <= 1);
        check("ready_lsb", ready_l, left_e <= 1);
        check("bit_valid_msb", bv_m, act_e);
        check("bit_valid_lsb", bv_l, act_e);
        check("busy_msb", busy_m, act_e);
        check("busy_lsb", busy_l, act_e);
        check("done_msb", done_m, done_e);
        check("done_lsb", done_l, done_e);
        check("sout_msb", sout_m, act_e ? word_e[left_e-1] : 1'b0);
        check("sout_lsb", sout_l, act_e ? word_e[4-left_e] : 1'b0);

        if (bv_m) log_m.push_back(sout_m);
        if (bv_l) log_l.push_back(sout_l);
        if (done_m) done_cnt++;
        if (prev_busy && !busy_m) busy_fall++;
        if (bv_m || busy_m || done_m || sout_m) nz_cnt++;
        if (!ready_m) rdy_low++;
        prev_busy = busy_m;
    end

    function automatic logic [15:0] pack_q(input bit q[$]);
        logic [15:0] acc = '0;
        foreach (q[i]) acc = {acc[14:0], q[i]};
        return acc;
    endfunction

    task automatic clear_log();
        log_m.delete();
        log_l.delete();
        done_cnt  = 0;
        busy_fall = 0;
        nz_cnt    = 0;
        rdy_low   = 0;
    endtask

    // Drive point: 1 time unit after the rising edge, away from the active edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        cyc(3);
        rst_n = 1'b1;

        // Idle with load low for 10 cycles.
        clear_log();
        cyc(10);
        check("idle_nonzero_cycles", nz_cnt, 0);
        check("idle_ready_low_cycles", rdy_low, 0);

        // Single frame 1011, both bit orders.
        clear_log();
        load = 1'b1; din = 4'b1011;
        cyc(1);
        load = 1'b0; din = 4'h0;
        cyc(6);
        check("t1_msb_len", log_m.size(), 4);
        check("t1_msb_bits", pack_q(log_m), 16'b1011);
        check("t2_lsb_bits", pack_q(log_l), 16'b1101);
        check("t1_done_pulses", done_cnt, 1);
        check("t1_ready_after", ready_m, 1'b1);
        check("t1_busy_after", busy_m, 1'b0);

        // Back-to-back A then 5.
        clear_log();
        load = 1'b1; din = 4'hA;
        cyc(1);
        din = 4'h5;
        cyc(4);
        load = 1'b0;
        cyc(6);
        check("t3_len", log_m.size(), 8);
        check("t3_msb_bits", pack_q(log_m), 16'b1010_0101);
        check("t3_lsb_bits", pack_q(log_l), 16'b0101_1010);
        check("t3_done_pulses", done_cnt, 2);
        check("t3_busy_falls", busy_fall, 1);

        // Load during bit 2 of C is ignored.
        clear_log();
        load = 1'b1; din = 4'hC;
        cyc(1);
        load = 1'b0;
        cyc(1);
        load = 1'b1; din = 4'h3;
        cyc(1);
        load = 1'b0;
        cyc(6);
        check("t4_len", log_m.size(), 4);
        check("t4_msb_bits", pack_q(log_m), 16'b1100);
        check("t4_done_pulses", done_cnt, 1);

        // Asynchronous reset during bit 3 of F.
        clear_log();
        load = 1'b1; din = 4'hF;
        cyc(1);
        load = 1'b0;
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_sout", {sout_m, sout_l}, 2'b00);
        check("t5_async_valid", {bv_m, bv_l}, 2'b00);
        check("t5_async_busy", {busy_m, busy_l}, 2'b00);
        check("t5_async_done", {done_m, done_l}, 2'b00);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        check("t5_bits_before_reset", pack_q(log_m), 16'b111);
        check("t5_no_done", done_cnt, 0);
        clear_log();
        load = 1'b1; din = 4'h9;
        cyc(1);
        load = 1'b0;
        cyc(6);
        check("t5_msb_bits", pack_q(log_m), 16'b1001);
        check("t5_lsb_bits", pack_q(log_l), 16'b1001);
        check("t5_done_pulses", done_cnt, 1);

        // Reset asserted with load high across a falling edge: nothing accepted.
        load = 1'b1; din = 4'h6;
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        load = 1'b0;
        #1;
        check("t7_no_accept_busy", busy_m, 1'b0);
        cyc(2);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            load = ($urandom_range(0, 2) != 0);
            din  = 4'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rst_n = 1'b0;
                cyc(1);
                rst_n = 1'b1;
            end else begin
                cyc(1);
            end
        end
        load = 1'b0;
        cyc(8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
